// File: rtl/tetris.sv
// Shared types for the playfield datapath.
package tetris;

  // One 4x4 piece bitmap; bit [r][c] is shape row r, column c.
  typedef logic [3:0][3:0] shape_t;

endpackage

// File: rtl/matrix_row_mask.sv
// Places one 4-bit shape row at column x of a playfield row, dropping columns past the right edge.
module matrix_row_mask #(
  parameter int unsigned width_p = 16
) (
  input  logic [3:0]                 shape_row_i,
  input  logic [$clog2(width_p)-1:0] x_i,
  output logic [width_p-1:0]         mask_o
);

  localparam int unsigned XW = $clog2(width_p);
  localparam int unsigned CW = XW + 1;

  logic [CW-1:0] col;

  // One extra bit on the column sum so x+c past the edge is seen rather than wrapped.
  always_comb begin
    mask_o = '0;
    col    = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      col = CW'(x_i) + CW'(c);
      if (col < CW'(width_p)) begin
        mask_o[col[XW-1:0]] = shape_row_i[c];
      end
    end
  end

endmodule

// File: rtl/matrix_memory.sv
// Playfield occupancy store: merges one 4x4 shape per commit, then collapses full rows
// bottom-up and reports how many were removed.
module matrix_memory
  import tetris::*;
#(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        write_v_i,
  input  logic [$clog2(width_p)-1:0]  write_addr_x_i,
  input  logic [$clog2(height_p)-1:0] write_addr_y_i,
  input  shape_t                      write_data_i,
  output logic                        is_ready_o,
  input  logic [$clog2(height_p)-1:0] read_addr_y_i,
  output logic [width_p-1:0]          read_row_o,
  output logic                        lines_cleared_v_o,
  output logic [2:0]                  lines_cleared_o
);

  localparam int unsigned XW  = $clog2(width_p);
  localparam int unsigned YW  = $clog2(height_p);
  localparam int unsigned YSW = YW + 1;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eMerge = 2'd1,
    eScan  = 2'd2,
    eShift = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  shape_t              data_q, data_d;
  logic [1:0]          row_cnt_q, row_cnt_d;
  logic [YW-1:0]       scan_q, scan_d;
  logic [2:0]          lines_q, lines_d;
  logic [width_p-1:0]  matrix_q [height_p];
  logic [width_p-1:0]  matrix_d [height_p];
  logic                is_ready_q, is_ready_d;
  logic                lines_cleared_v_q, lines_cleared_v_d;
  logic [2:0]          lines_cleared_q, lines_cleared_d;

  logic [YSW-1:0]      merge_row;
  logic [width_p-1:0]  merge_mask;

  matrix_row_mask #(
    .width_p(width_p)
  ) u_row_mask (
    .shape_row_i(data_q[row_cnt_q]),
    .x_i        (x_q),
    .mask_o     (merge_mask)
  );

  // Next-state, datapath updates and registered-output values.
  always_comb begin
    state_d           = state_q;
    x_d               = x_q;
    y_d               = y_q;
    data_d            = data_q;
    row_cnt_d         = row_cnt_q;
    scan_d            = scan_q;
    lines_d           = lines_q;
    matrix_d          = matrix_q;
    lines_cleared_v_d = 1'b0;
    lines_cleared_d   = lines_cleared_q;
    merge_row         = YSW'(y_q) + YSW'(row_cnt_q);

    case (state_q)
      eIDLE: begin
        if (write_v_i) begin
          x_d       = write_addr_x_i;
          y_d       = write_addr_y_i;
          data_d    = write_data_i;
          row_cnt_d = '0;
          state_d   = eMerge;
        end
      end

      eMerge: begin
        // Shape rows that fall below the floor are discarded, not wrapped to the top.
        if (merge_row < YSW'(height_p)) begin
          matrix_d[merge_row[YW-1:0]] = matrix_q[merge_row[YW-1:0]] | merge_mask;
        end
        row_cnt_d = row_cnt_q + 2'd1;
        if (row_cnt_q == 2'd3) begin
          scan_d  = YW'(height_p - 1);
          lines_d = '0;
          state_d = eScan;
        end
      end

      eScan: begin
        if (&matrix_q[scan_q]) begin
          state_d = eShift;
        end else if (scan_q == '0) begin
          state_d           = eIDLE;
          lines_cleared_v_d = 1'b1;
          lines_cleared_d   = lines_q;
        end else begin
          scan_d = scan_q - YW'(1);
        end
      end

      eShift: begin
        // Everything above the full row drops by one; the same row is rescanned next.
        for (int unsigned i = 1; i < height_p; i++) begin
          if (YW'(i) <= scan_q) begin
            matrix_d[i] = matrix_q[i-1];
          end
        end
        matrix_d[0] = '0;
        if (lines_q != 3'd4) begin
          lines_d = lines_q + 3'd1;
        end
        state_d = eScan;
      end

      default: begin
        state_d = eIDLE;
      end
    endcase

    is_ready_d = (state_d == eIDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= eIDLE;
      x_q               <= '0;
      y_q               <= '0;
      data_q            <= '0;
      row_cnt_q         <= '0;
      scan_q            <= '0;
      lines_q           <= '0;
      is_ready_q        <= 1'b1;
      lines_cleared_v_q <= 1'b0;
      lines_cleared_q   <= '0;
      for (int unsigned i = 0; i < height_p; i++) begin
        matrix_q[i] <= '0;
      end
    end else begin
      state_q           <= state_d;
      x_q               <= x_d;
      y_q               <= y_d;
      data_q            <= data_d;
      row_cnt_q         <= row_cnt_d;
      scan_q            <= scan_d;
      lines_q           <= lines_d;
      is_ready_q        <= is_ready_d;
      lines_cleared_v_q <= lines_cleared_v_d;
      lines_cleared_q   <= lines_cleared_d;
      for (int unsigned i = 0; i < height_p; i++) begin
        matrix_q[i] <= matrix_d[i];
      end
    end
  end

  assign is_ready_o        = is_ready_q;
  assign lines_cleared_v_o = lines_cleared_v_q;
  assign lines_cleared_o   = lines_cleared_q;
  assign read_row_o        = matrix_q[read_addr_y_i];

endmodule

// File: tb/tb_matrix_memory.sv
// Directed bench for matrix_memory: merge, clears, edge clipping, busy hold-off and reset.
module tb_matrix_memory;
  import tetris::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        write_v_i;
  logic [3:0]  write_addr_x_i;
  logic [4:0]  write_addr_y_i;
  shape_t      write_data_i;
  logic        is_ready_o;
  logic [4:0]  read_addr_y_i;
  logic [15:0] read_row_o;
  logic        lines_cleared_v_o;
  logic [2:0]  lines_cleared_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_rows [32];

  matrix_memory #(.width_p(16), .height_p(32)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .write_v_i        (write_v_i),
    .write_addr_x_i   (write_addr_x_i),
    .write_addr_y_i   (write_addr_y_i),
    .write_data_i     (write_data_i),
    .is_ready_o       (is_ready_o),
    .read_addr_y_i    (read_addr_y_i),
    .read_row_o       (read_row_o),
    .lines_cleared_v_o(lines_cleared_v_o),
    .lines_cleared_o  (lines_cleared_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i   = 1'b1;
    write_v_i = 1'b0;
    tick();
    reset_i   = 1'b0;
  endtask

  // Counts busy cycles until is_ready_o rises; also counts any early result pulses.
  task automatic wait_ready(output int busy, output int early);
    busy  = 0;
    early = 0;
    while (is_ready_o !== 1'b1 && busy < 500) begin
      busy++;
      if (lines_cleared_v_o === 1'b1) early++;
      tick();
    end
  endtask

  task automatic commit(input int x, input int y, input shape_t d, output int busy, output int early);
    write_addr_x_i = 4'(x);
    write_addr_y_i = 5'(y);
    write_data_i   = d;
    write_v_i      = 1'b1;
    tick();
    write_v_i      = 1'b0;
    wait_ready(busy, early);
  endtask

  task automatic clear_exp();
    for (int r = 0; r < 32; r++) exp_rows[r] = 16'h0000;
  endtask

  task automatic test_reset();
    do_reset();
    clear_exp();
    n_cmp++;
    if (is_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", is_ready_o); end
    n_cmp++;
    if (lines_cleared_v_o !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got=%b want=0", lines_cleared_v_o); end
    n_cmp++;
    if (lines_cleared_o !== 3'd0) begin n_bad++; $display("FAIL reset_lines got=%0d want=0", lines_cleared_o); end
    for (int r = 0; r < 32; r++) begin
      read_addr_y_i = 5'(r); #1;
      n_cmp++;
      if (read_row_o !== exp_rows[r]) begin n_bad++; $display("FAIL reset_row%0d got=%h want=%h", r, read_row_o, exp_rows[r]); end
    end
    tick();
  endtask

  task automatic test_basic_write();
    shape_t d;
    int busy, early;
    do_reset();
    clear_exp();
    d = '0; d[0] = 4'b0110;
    commit(3, 10, d, busy, early);
    exp_rows[10] = 16'h0030;
    n_cmp++;
    if (busy !== 36) begin n_bad++; $display("FAIL basic_busy got=%0d want=36", busy); end
    n_cmp++;
    if (early !== 0) begin n_bad++; $display("FAIL basic_early_pulse got=%0d want=0", early); end
    n_cmp++;
    if (lines_cleared_v_o !== 1'b1) begin n_bad++; $display("FAIL basic_pulse got=%b want=1", lines_cleared_v_o); end
    n_cmp++;
    if (lines_cleared_o !== 3'd0) begin n_bad++; $display("FAIL basic_lines got=%0d want=0", lines_cleared_o); end
    tick();
    n_cmp++;
    if (lines_cleared_v_o !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width got=%b want=0", lines_cleared_v_o); end
    for (int r = 0; r < 32; r++) begin
      read_addr_y_i = 5'(r); #1;
      n_cmp++;
      if (read_row_o !== exp_rows[r]) begin n_bad++; $display("FAIL basic_row%0d got=%h want=%h", r, read_row_o, exp_rows[r]); end
    end
    tick();
  endtask

  task automatic test_single_clear();
    shape_t d;
    int busy, early;
    do_reset();
    clear_exp();
    d = '0; d[3] = 4'hF; d[2] = 4'h1;
    commit(0, 28, d, busy, early);
    d = '0; d[3] = 4'hF;
    commit(4, 28, d, busy, early);
    commit(8, 28, d, busy, early);
    read_addr_y_i = 5'd31; #1;
    n_cmp++;
    if (read_row_o !== 16'h0FFF) begin n_bad++; $display("FAIL single_preload_row31 got=%h want=0fff", read_row_o); end
    read_addr_y_i = 5'd30; #1;
    n_cmp++;
    if (read_row_o !== 16'h0001) begin n_bad++; $display("FAIL single_preload_row30 got=%h want=0001", read_row_o); end
    tick();
    commit(12, 28, d, busy, early);
    exp_rows[31] = 16'h0001;
    n_cmp++;
    if (busy !== 38) begin n_bad++; $display("FAIL single_busy got=%0d want=38", busy); end
    n_cmp++;
    if (lines_cleared_v_o !== 1'b1) begin n_bad++; $display("FAIL single_pulse got=%b want=1", lines_cleared_v_o); end
    n_cmp++;
    if (lines_cleared_o !== 3'd1) begin n_bad++; $display("FAIL single_lines got=%0d want=1", lines_cleared_o); end
    tick();
    n_cmp++;
    if (lines_cleared_o !== 3'd1) begin n_bad++; $display("FAIL single_lines_hold got=%0d want=1", lines_cleared_o); end
    for (int r = 0; r < 32; r++) begin
      read_addr_y_i = 5'(r); #1;
      n_cmp++;
      if (read_row_o !== exp_rows[r]) begin n_bad++; $display("FAIL single_row%0d got=%h want=%h", r, read_row_o, exp_rows[r]); end
    end
    tick();
  endtask

  task automatic test_multi_clear();
    shape_t d;
    int busy, early;
    do_reset();
    clear_exp();
    d = '0; d[1] = 4'h1; d[2] = 4'hF; d[3] = 4'hF;
    commit(0, 28, d, busy, early);
    d = '0; d[2] = 4'hF; d[3] = 4'hF;
    commit(4, 28, d, busy, early);
    commit(8, 28, d, busy, early);
    commit(12, 28, d, busy, early);
    exp_rows[31] = 16'h0001;
    n_cmp++;
    if (busy !== 40) begin n_bad++; $display("FAIL multi_busy got=%0d want=40", busy); end
    n_cmp++;
    if (lines_cleared_o !== 3'd2) begin n_bad++; $display("FAIL multi_lines got=%0d want=2", lines_cleared_o); end
    n_cmp++;
    if (lines_cleared_v_o !== 1'b1) begin n_bad++; $display("FAIL multi_pulse got=%b want=1", lines_cleared_v_o); end
    for (int r = 0; r < 32; r++) begin
      read_addr_y_i = 5'(r); #1;
      n_cmp++;
      if (read_row_o !== exp_rows[r]) begin n_bad++; $display("FAIL multi_row%0d got=%h want=%h", r, read_row_o, exp_rows[r]); end
    end
    tick();
  endtask

  task automatic test_boundaries();
    shape_t d;
    int busy, early;
    do_reset();
    clear_exp();
    d = {4'hF, 4'hF, 4'hF, 4'hF};
    commit(14, 30, d, busy, early);
    n_cmp++;
    if (busy !== 36) begin n_bad++; $display("FAIL edge_busy got=%0d want=36", busy); end
    n_cmp++;
    if (lines_cleared_o !== 3'd0) begin n_bad++; $display("FAIL edge_lines got=%0d want=0", lines_cleared_o); end
    d = '0; d[0] = 4'h1; d[1] = 4'hF;
    commit(0, 31, d, busy, early);
    exp_rows[30] = 16'hC000;
    exp_rows[31] = 16'hC001;
    for (int r = 0; r < 32; r++) begin
      read_addr_y_i = 5'(r); #1;
      n_cmp++;
      if (read_row_o !== exp_rows[r]) begin n_bad++; $display("FAIL edge_row%0d got=%h want=%h", r, read_row_o, exp_rows[r]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    shape_t d;
    int busy, early, pulses;
    do_reset();
    d = '0; d[0] = 4'h1;
    write_addr_x_i = 4'd0;
    write_addr_y_i = 5'd0;
    write_data_i   = d;
    write_v_i      = 1'b1;
    tick();
    write_addr_x_i = 4'd4;
    wait_ready(busy, early);
    n_cmp++;
    if (busy !== 36) begin n_bad++; $display("FAIL b2b_busy1 got=%0d want=36", busy); end
    read_addr_y_i = 5'd0; #1;
    n_cmp++;
    if (read_row_o !== 16'h0001) begin n_bad++; $display("FAIL b2b_row0_first got=%h want=0001", read_row_o); end
    tick();
    n_cmp++;
    if (is_ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_reaccept got=%b want=0", is_ready_o); end
    wait_ready(busy, early);
    write_v_i = 1'b0;
    n_cmp++;
    if (busy !== 36) begin n_bad++; $display("FAIL b2b_busy2 got=%0d want=36", busy); end
    read_addr_y_i = 5'd0; #1;
    n_cmp++;
    if (read_row_o !== 16'h0011) begin n_bad++; $display("FAIL b2b_row0_second got=%h want=0011", read_row_o); end
    tick();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (is_ready_o !== 1'b1) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL b2b_idle_after_drop busy_cycles=%0d want=0", pulses); end
  endtask

  task automatic test_reset_mid_scan();
    shape_t d;
    int pulses;
    do_reset();
    clear_exp();
    d = '0; d[0] = 4'hF;
    write_addr_x_i = 4'd0;
    write_addr_y_i = 5'd0;
    write_data_i   = d;
    write_v_i      = 1'b1;
    tick();
    write_v_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    read_addr_y_i = 5'd0; #1;
    n_cmp++;
    if (read_row_o !== 16'h000F) begin n_bad++; $display("FAIL midscan_row0_before got=%h want=000f", read_row_o); end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_cmp++;
    if (is_ready_o !== 1'b1) begin n_bad++; $display("FAIL midscan_ready got=%b want=1", is_ready_o); end
    for (int r = 0; r < 32; r++) begin
      read_addr_y_i = 5'(r); #1;
      n_cmp++;
      if (read_row_o !== exp_rows[r]) begin n_bad++; $display("FAIL midscan_row%0d got=%h want=%h", r, read_row_o, exp_rows[r]); end
    end
    tick();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (lines_cleared_v_o !== 1'b0) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL midscan_pulse got=%0d want=0", pulses); end
  endtask

  initial begin
    reset_i        = 1'b1;
    write_v_i      = 1'b0;
    write_addr_x_i = '0;
    write_addr_y_i = '0;
    write_data_i   = '0;
    read_addr_y_i  = '0;
    tick();
    test_reset();
    test_basic_write();
    test_single_clear();
    test_multi_clear();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
